// File: rtl/mem_pkg.sv
// Shared definitions for the MEM-stage load/store unit: RV32I width codes,
// LSU state encoding and the funct3 legality rule.
package mem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam int BE_W = 4;

    typedef enum logic [1:0] {
        LSU_IDLE = 2'd0,
        LSU_BUSY = 2'd1,
        LSU_RESP = 2'd2
    } lsu_state_e;

    // Loads take all five codes; stores have no unsigned variants.
    function automatic logic f3_legal(input logic we, input logic [2:0] f3);
        logic ok;
        ok = 1'b0;
        case (f3)
            F3_B, F3_H, F3_W: ok = 1'b1;
            F3_BU, F3_HU:     ok = !we;
            default:          ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: byte enables, store-data replication, load
// extraction/extension and the misaligned/illegal classification.
module lsu_align
    import mem_pkg::*;
(
    input  logic            we,
    input  logic [2:0]      funct3,
    input  logic [1:0]      addr_lo,
    input  logic [31:0]     wdata,
    input  logic [31:0]     rdata,
    output logic [BE_W-1:0] be,
    output logic [31:0]     wdata_lane,
    output logic [31:0]     rdata_ext,
    output logic            misaligned,
    output logic            illegal
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = 8'h00;
        case (addr_lo)
            2'd0: byte_sel = rdata[7:0];
            2'd1: byte_sel = rdata[15:8];
            2'd2: byte_sel = rdata[23:16];
            2'd3: byte_sel = rdata[31:24];
            default: byte_sel = 8'h00;
        endcase
        half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    end

    always_comb begin
        be         = '0;
        wdata_lane = wdata;
        rdata_ext  = '0;
        misaligned = 1'b0;
        illegal    = !f3_legal(we, funct3);
        case (funct3)
            F3_B, F3_BU: begin
                be         = 4'b0001 << addr_lo;
                wdata_lane = {4{wdata[7:0]}};
                rdata_ext  = (funct3 == F3_B) ? {{24{byte_sel[7]}}, byte_sel}
                                              : {24'h000000, byte_sel};
            end
            F3_H, F3_HU: begin
                be         = addr_lo[1] ? 4'b1100 : 4'b0011;
                misaligned = addr_lo[0];
                wdata_lane = {2{wdata[15:0]}};
                rdata_ext  = (funct3 == F3_H) ? {{16{half_sel[15]}}, half_sel}
                                              : {16'h0000, half_sel};
            end
            F3_W: begin
                be         = 4'b1111;
                misaligned = |addr_lo;
                rdata_ext  = rdata;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/pipeline_mem_lsu.sv
// MEM-stage load/store unit: IDLE/BUSY/RESP sequencer with a bus timeout,
// pipeline stall generation and one-cycle result/exception pulses.
module pipeline_mem_lsu
    import mem_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    input  logic            req_we,
    input  logic [2:0]      req_funct3,
    input  logic [31:0]     req_addr,
    input  logic [31:0]     req_wdata,
    input  logic            flush_in,
    output logic            stall_out,
    output logic            done_out,
    output logic [31:0]     load_data_out,
    output logic            misalign_out,
    output logic            fault_out,
    output logic            bus_req,
    output logic            bus_we,
    output logic [31:0]     bus_addr,
    output logic [BE_W-1:0] bus_be,
    output logic [31:0]     bus_wdata,
    input  logic            bus_ready,
    input  logic [31:0]     bus_rdata,
    output logic [1:0]      dbg_state
);

    localparam logic [1:0] S_IDLE = 2'(LSU_IDLE);
    localparam logic [1:0] S_BUSY = 2'(LSU_BUSY);
    localparam logic [1:0] S_RESP = 2'(LSU_RESP);

    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [1:0]      state;
    logic            we_q;
    logic [2:0]      f3_q;
    logic [31:0]     addr_q;
    logic [31:0]     wdata_q;
    logic [31:0]     load_q;
    logic [CW-1:0]   cnt_q;
    logic            timeout_q;
    logic            misalign_q;
    logic            illegal_q;

    logic            idle, busy, resp;
    logic            req_take, accept, reject;
    logic            al_we;
    logic [2:0]      al_f3;
    logic [1:0]      al_addr_lo;
    logic [31:0]     al_wdata;
    logic [BE_W-1:0] al_be;
    logic [31:0]     al_wlane;
    logic [31:0]     al_rext;
    logic            al_mis;
    logic            al_ill;

    assign idle = (state == S_IDLE);
    assign busy = (state == S_BUSY);
    assign resp = (state == S_RESP);

    // One align instance: it classifies the incoming request in IDLE and
    // drives lanes from the latched request while BUSY.
    assign al_we      = busy ? we_q        : req_we;
    assign al_f3      = busy ? f3_q        : req_funct3;
    assign al_addr_lo = busy ? addr_q[1:0] : req_addr[1:0];
    assign al_wdata   = busy ? wdata_q     : req_wdata;

    lsu_align u_align (
        .we         (al_we),
        .funct3     (al_f3),
        .addr_lo    (al_addr_lo),
        .wdata      (al_wdata),
        .rdata      (bus_rdata),
        .be         (al_be),
        .wdata_lane (al_wlane),
        .rdata_ext  (al_rext),
        .misaligned (al_mis),
        .illegal    (al_ill)
    );

    assign req_take = idle && req_valid && !flush_in;
    assign accept   = req_take && !al_mis && !al_ill;
    assign reject   = req_take && (al_mis || al_ill);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            we_q       <= 1'b0;
            f3_q       <= 3'b000;
            addr_q     <= '0;
            wdata_q    <= '0;
            load_q     <= '0;
            cnt_q      <= '0;
            timeout_q  <= 1'b0;
            misalign_q <= 1'b0;
            illegal_q  <= 1'b0;
        end else begin
            misalign_q <= reject && al_mis;
            illegal_q  <= reject && !al_mis && al_ill;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        we_q      <= req_we;
                        f3_q      <= req_funct3;
                        addr_q    <= req_addr;
                        wdata_q   <= req_wdata;
                        cnt_q     <= '0;
                        timeout_q <= 1'b0;
                        state     <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    // Ready wins over a timeout landing in the same cycle.
                    if (bus_ready) begin
                        load_q    <= we_q ? 32'h0 : al_rext;
                        timeout_q <= 1'b0;
                        state     <= S_RESP;
                    end else if (cnt_q == CNT_LAST) begin
                        load_q    <= '0;
                        timeout_q <= 1'b1;
                        state     <= S_RESP;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_RESP:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Bus handshake: while bus_req is high the address, byte enables, write
    // flag and write data hold steady; the transfer completes in the cycle
    // bus_ready is sampled high, and bus_rdata is only looked at then.
    assign bus_req   = busy;
    assign bus_we    = busy && we_q;
    assign bus_addr  = busy ? {addr_q[31:2], 2'b00} : 32'h0;
    assign bus_be    = busy ? al_be : '0;
    assign bus_wdata = (busy && we_q) ? al_wlane : 32'h0;

    assign stall_out     = accept || busy;
    assign done_out      = resp;
    assign load_data_out = resp ? load_q : 32'h0;
    assign misalign_out  = misalign_q;
    assign fault_out     = illegal_q || (resp && timeout_q);
    assign dbg_state     = state;

endmodule

// File: tb/tb_pipeline_mem_lsu.sv
// Randomized bench for pipeline_mem_lsu against an arithmetic reference
// model of the access rules, with directed cases for the listed scenarios.
module tb_pipeline_mem_lsu;

    localparam int TO = 4;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        flush_in;
    logic        stall_out;
    logic        done_out;
    logic [31:0] load_data_out;
    logic        misalign_out;
    logic        fault_out;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_ready;
    logic [31:0] bus_rdata;
    logic [1:0]  dbg_state;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] exp_q[$];

    pipeline_mem_lsu #(.TIMEOUT_CYCLES(TO)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_we        (req_we),
        .req_funct3    (req_funct3),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .flush_in      (flush_in),
        .stall_out     (stall_out),
        .done_out      (done_out),
        .load_data_out (load_data_out),
        .misalign_out  (misalign_out),
        .fault_out     (fault_out),
        .bus_req       (bus_req),
        .bus_we        (bus_we),
        .bus_addr      (bus_addr),
        .bus_be        (bus_be),
        .bus_wdata     (bus_wdata),
        .bus_ready     (bus_ready),
        .bus_rdata     (bus_rdata),
        .dbg_state     (dbg_state)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // reference model
    function automatic int size_of(input logic [2:0] f3);
        if (f3 == 3'b000 || f3 == 3'b100) return 1;
        if (f3 == 3'b001 || f3 == 3'b101) return 2;
        return 4;
    endfunction

    function automatic bit ref_legal(input bit we, input logic [2:0] f3);
        if (we) return (f3 inside {3'b000, 3'b001, 3'b010});
        return (f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    endfunction

    function automatic bit ref_misal(input logic [2:0] f3, input logic [31:0] addr);
        if (!(f3 inside {3'b001, 3'b101, 3'b010})) return 1'b0;
        return (addr % size_of(f3)) != 0;
    endfunction

    function automatic logic [3:0] ref_be(input logic [2:0] f3, input logic [31:0] addr);
        int sz = size_of(f3);
        int lo = int'(addr % 4);
        return 4'(((1 << sz) - 1) << lo);
    endfunction

    function automatic logic [31:0] ref_wlane(input logic [2:0] f3, input logic [31:0] w);
        int sz = size_of(f3);
        if (sz == 1) return (w & 32'hFF) * 32'h0101_0101;
        if (sz == 2) return (w & 32'hFFFF) * 32'h0001_0001;
        return w;
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] addr,
                                             input logic [31:0] rdata);
        int sz = size_of(f3);
        logic [31:0] v, mask;
        v = rdata >> (8 * (addr % 4));
        if (sz == 4) return v;
        mask = (32'h1 << (8 * sz)) - 1;
        v = v & mask;
        if (f3 < 3'b100 && v[8 * sz - 1]) v = v | ~mask;
        return v;
    endfunction

    // driver: one instruction presented to the LSU, checked cycle by cycle
    task automatic run_access(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] wdata, input int ready_at,
                              input logic [31:0] rdata, input bit flush);
        bit err, mis, timed_out;
        err = !ref_legal(we, f3) || ref_misal(f3, addr);
        mis = ref_misal(f3, addr);
        timed_out = (ready_at >= TO);

        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        flush_in   = flush;
        #1;
        if (flush || err) begin
            chk("stall_reject", {31'b0, stall_out}, 32'd0);
            @(negedge clk);
            req_valid = 1'b0;
            flush_in  = 1'b0;
            #1;
            chk("misalign_pulse", {31'b0, misalign_out}, {31'b0, !flush && mis});
            chk("fault_pulse", {31'b0, fault_out}, {31'b0, !flush && !mis});
            chk("bus_req_reject", {31'b0, bus_req}, 32'd0);
            chk("stall_reject_t1", {31'b0, stall_out}, 32'd0);
            @(negedge clk);
            #1;
            chk("misalign_one_cycle", {31'b0, misalign_out}, 32'd0);
            chk("fault_one_cycle", {31'b0, fault_out}, 32'd0);
            return;
        end

        chk("stall_accept", {31'b0, stall_out}, 32'd1);
        if (!we) exp_q.push_back(timed_out ? 32'h0 : ref_load(f3, addr, rdata));

        for (int c = 0; c < TO; c++) begin
            @(negedge clk);
            bus_ready = (c == ready_at);
            bus_rdata = (c == ready_at) ? rdata : $urandom;
            #1;
            chk("bus_req_busy", {31'b0, bus_req}, 32'd1);
            chk("bus_we", {31'b0, bus_we}, {31'b0, we});
            chk("bus_addr", bus_addr, {addr[31:2], 2'b00});
            chk("bus_be", {28'b0, bus_be}, {28'b0, ref_be(f3, addr)});
            if (we) chk("bus_wdata", bus_wdata, ref_wlane(f3, wdata));
            chk("stall_busy", {31'b0, stall_out}, 32'd1);
            chk("done_busy", {31'b0, done_out}, 32'd0);
            if (c == ready_at) break;
        end

        @(negedge clk);
        bus_ready = 1'b0;
        #1;
        chk("done_resp", {31'b0, done_out}, 32'd1);
        chk("fault_resp", {31'b0, fault_out}, {31'b0, timed_out});
        chk("bus_req_resp", {31'b0, bus_req}, 32'd0);
        chk("stall_resp", {31'b0, stall_out}, 32'd0);
        if (!we) chk("load_data", load_data_out, exp_q.pop_front());
        req_valid = 1'b0;

        @(negedge clk);
        #1;
        chk("done_drop", {31'b0, done_out}, 32'd0);
        chk("fault_drop", {31'b0, fault_out}, 32'd0);
        chk("load_data_idle", load_data_out, 32'h0);
    endtask

    initial begin
        logic [2:0] f3_tab [8];
        f3_tab = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b011, 3'b110, 3'b111};

        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000;
        req_addr = '0; req_wdata = '0; flush_in = 1'b0; bus_ready = 1'b0; bus_rdata = '0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_state", {30'b0, dbg_state}, 32'd0);
        chk("rst_bus_req", {31'b0, bus_req}, 32'd0);
        chk("rst_bus_addr", bus_addr, 32'h0);
        chk("rst_bus_be", {28'b0, bus_be}, 32'd0);
        chk("rst_stall", {31'b0, stall_out}, 32'd0);
        chk("rst_done", {31'b0, done_out}, 32'd0);
        chk("rst_load", load_data_out, 32'h0);
        chk("rst_pulses", {30'b0, misalign_out, fault_out}, 32'd0);
        rst_n = 1'b1;

        // directed scenarios
        run_access(1'b1, 3'b010, 32'h0000_1004, 32'hDEAD_BEEF, 0, 32'h0, 1'b0);
        run_access(1'b0, 3'b000, 32'h0000_2003, 32'h0, 1, 32'h80FF_0000, 1'b0);
        run_access(1'b0, 3'b100, 32'h0000_2003, 32'h0, 2, 32'h80FF_0000, 1'b0);
        run_access(1'b1, 3'b001, 32'h0000_3002, 32'h0000_1234, 0, 32'h0, 1'b0);
        run_access(1'b0, 3'b101, 32'h0000_3002, 32'h0, 0, 32'hABCD_0000, 1'b0);
        run_access(1'b0, 3'b010, 32'h0000_4002, 32'h0, 0, 32'h0, 1'b0);
        run_access(1'b0, 3'b011, 32'h0000_4000, 32'h0, 0, 32'h0, 1'b0);
        run_access(1'b0, 3'b010, 32'h0000_5000, 32'h0, 99, 32'h0, 1'b0);
        run_access(1'b0, 3'b010, 32'h0000_5004, 32'h0, TO - 1, 32'h1357_9BDF, 1'b0);
        run_access(1'b1, 3'b100, 32'h0000_6000, 32'h55, 0, 32'h0, 1'b0);

        // randomized traffic
        for (int i = 0; i < 80; i++) begin
            int k;
            logic [31:0] a;
            k = $urandom_range(0, 10);
            a = $urandom;
            if ($urandom_range(0, 1) == 0) a[1:0] = 2'b00;
            run_access(1'($urandom_range(0, 1)), (k > 7) ? 3'b010 : f3_tab[k], a, $urandom,
                       $urandom_range(0, 5), $urandom, $urandom_range(0, 9) == 0);
        end

        // reset in the middle of a transfer
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h0000_7000;
        @(negedge clk);
        #1;
        chk("busy_before_rst", {31'b0, bus_req}, 32'd1);
        rst_n = 1'b0;
        req_valid = 1'b0;
        #1;
        chk("rst_mid_bus_req", {31'b0, bus_req}, 32'd0);
        chk("rst_mid_stall", {31'b0, stall_out}, 32'd0);
        chk("rst_mid_state", {30'b0, dbg_state}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // flushed request after reset release
        run_access(1'b0, 3'b010, 32'h0000_8000, 32'h0, 0, 32'h0, 1'b1);
        run_access(1'b1, 3'b000, 32'h0000_8001, 32'hA5, 1, 32'h0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pipeline_mem_lsu.md
# pipeline_mem_lsu

Load/store unit for the MEM stage of the pipelined RV32I core. It consumes the EX-stage results latched in EX/MEM: the ALU result is the effective address and the forwarded Rs2 value is the store data. It runs a valid/ready transaction on the data bus, aligns and extends load data, and stalls the pipeline until the access completes.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 16: BUSY cycles without `bus_ready` before a bus error is raised (≥1).

Ports (one clock; reset is asynchronous and active-low):
- `clk` input 1: rising-edge clock.
- `rst_n` input 1: asynchronous active-low reset.
- `req_valid` input 1: EX/MEM holds a load or store.
- `req_we` input 1: 1 = store, 0 = load.
- `req_funct3` input 3: access width and sign (RV32I encoding).
- `req_addr` input 32: effective address (ALU result from EX).
- `req_wdata` input 32: store data (Rs2 from EX).
- `flush_in` input 1: kill the request currently presented in IDLE.
- `stall_out` output 1: hold PC/IF/ID/EX/EX-MEM registers.
- `done_out` output 1: one-cycle pulse, access finished.
- `load_data_out` output 32: aligned, extended load result; valid while `done_out`.
- `misalign_out` output 1: one-cycle pulse, misaligned address.
- `fault_out` output 1: one-cycle pulse, illegal funct3 or bus timeout.
- `bus_req` output 1: bus request.
- `bus_we` output 1: bus write.
- `bus_addr` output 32: word-aligned address (`[1:0]`=0).
- `bus_be` output 4: byte enables.
- `bus_wdata` output 32: lane-shifted store data.
- `bus_ready` input 1: bus accepts/completes the transfer this cycle.
- `bus_rdata` input 32: read word; valid when `bus_ready`.

## Operation
- Width codes: 000 B, 001 H, 010 W, 100 BU, 101 HU. Loads accept all five. Stores accept 000/001/010 only. Any other code is illegal.
- Misalignment: H/HU with `addr[0]`=1; W with `addr[1:0]`≠0.
- Byte enables:
  - B: `1<<addr[1:0]`.
  - H: `addr[1]` ? 1100 : 0011.
  - W: 1111.
- Store data: byte replicated to all four lanes, halfword to both halves.
- Load extraction: take the selected byte or half from `bus_rdata` using `addr[1:0]`. B/H sign-extend; BU/HU zero-extend.
- FSM states: IDLE, BUSY, RESP.
  - IDLE, `req_valid` & !`flush_in`, legal and aligned: latch we/funct3/addr/wdata, clear the timeout counter, go to BUSY.
  - IDLE, `req_valid` & !`flush_in`, illegal or misaligned: pulse `misalign_out`/`fault_out` next cycle (misalign takes priority), stay in IDLE, no bus access.
  - BUSY: `bus_req`=1 with registered fields stable.
    - `bus_ready` high: capture the extended load data and go to RESP.
    - Counter reaches `TIMEOUT_CYCLES`-1 with no `bus_ready`: set fault, `load_data_out`=0, go to RESP.
  - RESP: `done_out`=1, `fault_out` reflects timeout, `req_valid` ignored (the same instruction is still presented), go to IDLE.
- `stall_out` = (IDLE & `req_valid` & !`flush_in` & legal & aligned) | BUSY. `stall_out` is combinational in IDLE.
- `flush_in` is ignored in BUSY/RESP; a started transfer always completes.
- All bus outputs are zero outside BUSY.

## Timing
- Reset values: state IDLE; all outputs 0 (`load_data_out`=0, `bus_*`=0, pulses 0).
- Reset mid-BUSY: `bus_req` drops asynchronously and the transaction is abandoned.
- Accept in cycle T0 → `bus_req` from T1. `bus_ready` sampled at Tk → `done_out` in Tk+1.
- Minimum access: 3 cycles; `stall_out` high T0..Tk.
- `misalign_out`/`fault_out` pulse in T0+1 and last one cycle.
- Timeout: with `bus_ready` held low, `bus_req` stays high for exactly `TIMEOUT_CYCLES` cycles.
- `bus_ready` arriving in the same cycle as the final timeout count: ready wins, no fault.

## Structure
- Shared package `mem_pkg`:
  - Funct3 width constants (`F3_B`..`F3_HU`).
  - LSU state enum.
  - Byte-enable width constant.
- Sub-module `lsu_align` (combinational):
  - Inputs: funct3, addr[1:0], wdata, rdata.
  - Outputs: be, shifted wdata, extended rdata, misaligned, illegal.
- The FSM, registers and timeout counter stay in the top module.

## Test plan
- SW addr 0x0000_1004, wdata 0xDEADBEEF, `bus_ready` at T1 → T1 `bus_addr`=0x1004, `bus_be`=1111, `bus_wdata`=0xDEADBEEF; `done_out` at T2; `stall_out` high T0–T1.
- LB addr 0x...03, `bus_rdata`=0x80FF_0000 → `load_data_out`=0xFFFF_FF80. LBU, same inputs → 0x0000_0080.
- SH addr 0x...02, wdata 0x0000_1234 → `bus_be`=1100, `bus_wdata`=0x1234_1234. LHU addr 0x...02, `rdata`=0xABCD_0000 → 0x0000_ABCD.
- LW addr 0x...02 → `misalign_out` pulses at T1, `bus_req` never asserts, `stall_out` 0. funct3=011 load → `fault_out` pulse.
- LW, `bus_ready` held low, `TIMEOUT_CYCLES`=4 → `bus_req` high 4 cycles, then `done_out`=1, `fault_out`=1, `load_data_out`=0.
- `rst_n` low during BUSY → `bus_req` and `stall_out` drop immediately. After release, `flush_in` with `req_valid` in IDLE → no bus access, no stall.
